// File: rtl/cpu_debug_pkg.sv
// Shared CPU debug definitions: run-sequencer state encoding and the
// register width default used by the CPU and its bring-up logic.
package cpu_debug_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DONE  = 3'd4
  } run_state_t;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Debug bus between the run controller and the register file / dump sink:
// combinational register-file read port plus the registered dump stream.
interface cpu_run_controller_if
  import cpu_debug_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = 5
) ();

  logic [AW-1:0]   rf_raddr;
  logic [XLEN-1:0] rf_rdata;
  logic            dump_valid;
  logic [AW-1:0]   dump_idx;
  logic [XLEN-1:0] dump_data;

  modport master (
    output rf_raddr,
    input  rf_rdata,
    output dump_valid,
    output dump_idx,
    output dump_data
  );

  modport slave (
    input  rf_raddr,
    output rf_rdata,
    input  dump_valid,
    input  dump_idx,
    input  dump_data
  );

endinterface

// File: rtl/run_timer.sv
// Up-counter with synchronous clear and enable, plus a terminal-count flag
// against a run-time terminal value so one counter can time several phases.
module run_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  // count while enabled; clear has priority so a phase always starts at zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/cpu_run_controller.sv
// CPU bring-up run/dump sequencer: holds the CPU in reset, runs it until halt
// or a cycle budget, freezes it, streams the register file out and reports
// done/pass.
module cpu_run_controller
  import cpu_debug_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int NUM_REGS     = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 10000,
  parameter int HALT_EN      = 1,
  parameter int CHECK_REG    = 10,
  localparam int AW = $clog2(NUM_REGS),
  localparam int CW = $clog2(MAX_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 check_en,
  input  logic [XLEN-1:0]      expect_val,
  cpu_run_controller_if.master dbg,
  output logic                 cpu_reset,
  output logic [CW-1:0]        cycle_count,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timed_out
);

  // one timer serves the reset hold and the run budget, so it must span both
  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int TW = (CW > RW) ? CW : RW;

  localparam logic [TW-1:0] HOLD_TERM   = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] BUDGET_TERM = TW'(MAX_CYCLES - 1);
  localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] CHECK_IDX   = AW'(CHECK_REG);

  run_state_t      state, state_nxt;
  logic            start_acc, run_enter, run_exit, last_dump;
  logic            halt_hit;
  logic            tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0]   tmr_term, tmr_cnt;
  logic            to_q;
  logic [AW-1:0]   rd_idx_p0;
  logic            dump_vld_p1;
  logic [AW-1:0]   dump_idx_p1;
  logic [XLEN-1:0] dump_data_p1;
  logic [XLEN-1:0] chk_val;

  assign halt_hit = halt && (HALT_EN != 0);

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and phase-transition strobes
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    run_enter = 1'b0;
    run_exit  = 1'b0;
    last_dump = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = ST_RESET;
        end
      end
      ST_RESET: begin
        if (tmr_tc) begin
          run_enter = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // halt takes precedence over the budget when both land together
        if (halt_hit || tmr_tc) begin
          run_exit  = 1'b1;
          state_nxt = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (rd_idx_p0 == LAST_IDX) begin
          last_dump = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // timer restarts on start and again on entry to RUN so cycle_count is RUN-only
  assign tmr_clr  = start_acc || run_enter;
  assign tmr_en   = (state == ST_RESET) || (state == ST_RUN);
  assign tmr_term = (state == ST_RUN) ? BUDGET_TERM : HOLD_TERM;

  run_timer #(
    .W(TW)
  ) u_timer (
    .clk   (clk),
    .rst   (reset),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .count (tmr_cnt),
    .tc    (tmr_tc)
  );

  // timed_out is decided at RUN exit and kept until the next start
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      to_q <= 1'b0;
    end else if (run_exit) begin
      to_q <= !halt_hit;
    end
  end

  // p0: dump read index driving the register-file address
  always_ff @(posedge clk) begin
    if (reset || run_exit) begin
      rd_idx_p0 <= '0;
    end else if ((state == ST_DUMP) && !last_dump) begin
      rd_idx_p0 <= rd_idx_p0 + AW'(1);
    end
  end

  // p1: registered dump stream, one cycle behind the read address
  always_ff @(posedge clk) begin
    if (reset) begin
      dump_vld_p1  <= 1'b0;
      dump_idx_p1  <= '0;
      dump_data_p1 <= '0;
    end else begin
      dump_vld_p1 <= (state == ST_DUMP);
      if (state == ST_DUMP) begin
        dump_idx_p1  <= rd_idx_p0;
        dump_data_p1 <= dbg.rf_rdata;
      end
    end
  end

  // capture of the checked register as it streams past
  always_ff @(posedge clk) begin
    if ((state == ST_DUMP) && (rd_idx_p0 == CHECK_IDX)) begin
      chk_val <= dbg.rf_rdata;
    end
  end

  assign dbg.rf_raddr   = (state == ST_DUMP) ? rd_idx_p0 : '0;
  assign dbg.dump_valid = dump_vld_p1;
  assign dbg.dump_idx   = dump_idx_p1;
  assign dbg.dump_data  = dump_data_p1;

  assign cpu_reset   = (state != ST_RUN);
  assign busy        = (state == ST_RESET) || (state == ST_RUN) || (state == ST_DUMP);
  assign done        = (state == ST_DONE);
  assign pass        = done && !to_q && (!check_en || (chk_val == expect_val));
  assign timed_out   = to_q;
  assign cycle_count = (state == ST_RESET) ? '0 : tmr_cnt[CW-1:0];

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: two instances (HALT_EN=1 and HALT_EN=0) share
// all stimulus; each is compared against a run-level reference model.
module tb_cpu_run_controller;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 4;
  localparam int RC       = 2;
  localparam int MAXC     = 100;
  localparam int CHK      = 2;
  localparam int AW       = $clog2(NUM_REGS);
  localparam int CW       = $clog2(MAXC + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, start, halt, check_en;
  logic [XLEN-1:0] expect_val;
  logic [XLEN-1:0] rf [NUM_REGS];

  logic [1:0]      cpu_reset_o, busy_o, done_o, pass_o, to_o, dv_o;
  logic [CW-1:0]   cnt_o   [2];
  logic [AW-1:0]   idx_o   [2];
  logic [AW-1:0]   raddr_o [2];
  logic [XLEN-1:0] data_o  [2];

  int n_tests = 0;
  int n_fail  = 0;

  int exp_cnt [2];
  bit exp_to  [2];
  bit exp_ps  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_run_controller_if #(.XLEN(XLEN), .AW(AW)) dbg ();
    assign dbg.rf_rdata = rf[dbg.rf_raddr];
    assign dv_o[g]      = dbg.dump_valid;
    assign idx_o[g]     = dbg.dump_idx;
    assign data_o[g]    = dbg.dump_data;
    assign raddr_o[g]   = dbg.rf_raddr;

    cpu_run_controller #(
      .XLEN         (XLEN),
      .NUM_REGS     (NUM_REGS),
      .RESET_CYCLES (RC),
      .MAX_CYCLES   (MAXC),
      .HALT_EN      ((g == 0) ? 1 : 0),
      .CHECK_REG    (CHK)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .halt        (halt),
      .check_en    (check_en),
      .expect_val  (expect_val),
      .dbg         (dbg),
      .cpu_reset   (cpu_reset_o[g]),
      .cycle_count (cnt_o[g]),
      .busy        (busy_o[g]),
      .done        (done_o[g]),
      .pass        (pass_o[g]),
      .timed_out   (to_o[g])
    );
  end

  typedef struct {
    int          h;     // RUN cycle at which halt is raised (0 = never)
    bit          hold;  // 1: halt stays high from cycle h on
    bit          chk;
    logic [31:0] ev;
    logic [31:0] rf2;
    int          cnt;   // expected cycle_count of the HALT_EN=1 instance
    bit          to;
    bit          ps;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic string tag(input int g);
    return (g == 0) ? "he1" : "he0";
  endfunction

  // Run-level reference: what the sequencer must report for a given halt time.
  function automatic void model(input bit halt_en, input int h, input bit chk,
                                input logic [XLEN-1:0] ev,
                                output int cnt, output bit to, output bit ps);
    bit halted;
    halted = halt_en && (h >= 1) && (h <= MAXC);
    cnt    = halted ? h : MAXC;
    to     = !halted;
    ps     = !to && (!chk || (rf[CHK] == ev));
  endfunction

  task automatic fill_rf();
    for (int k = 0; k < NUM_REGS; k++) rf[k] = $urandom;
  endtask

  task automatic check_reset_state(input string pfx);
    for (int g = 0; g < 2; g++) begin
      check({pfx, ".", tag(g), ".cpu_reset"}, 64'(cpu_reset_o[g]), 64'd1);
      check({pfx, ".", tag(g), ".busy"},      64'(busy_o[g]),      64'd0);
      check({pfx, ".", tag(g), ".done"},      64'(done_o[g]),      64'd0);
      check({pfx, ".", tag(g), ".pass"},      64'(pass_o[g]),      64'd0);
      check({pfx, ".", tag(g), ".timed_out"}, 64'(to_o[g]),        64'd0);
      check({pfx, ".", tag(g), ".count"},     64'(cnt_o[g]),       64'd0);
      check({pfx, ".", tag(g), ".dump_valid"},64'(dv_o[g]),        64'd0);
      check({pfx, ".", tag(g), ".rf_raddr"},  64'(raddr_o[g]),     64'd0);
    end
  endtask

  // One complete run from IDLE or DONE; exp_* must be set beforehand.
  task automatic do_run(input string nm, input int h, input bit hold, input bit chk,
                        input logic [XLEN-1:0] ev, input bit noise);
    int hold_n [2];
    int low_n  [2];
    int npulse [2];
    int first_p[2];
    int last_p [2];
    int bad_d  [2];
    int bad_a  [2];
    bit seen_low[2];
    bit got_done[2];
    int ridx;
    int cyc;
    for (int g = 0; g < 2; g++) begin
      hold_n[g] = 0; low_n[g] = 0; npulse[g] = 0; first_p[g] = 0; last_p[g] = 0;
      bad_d[g] = 0; bad_a[g] = 0; seen_low[g] = 1'b0; got_done[g] = 1'b0;
    end
    @(negedge clk);
    check_en = chk; expect_val = ev; halt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ridx = 0;
    cyc  = 0;
    while (!(got_done[0] && got_done[1]) && (cyc < 600)) begin
      for (int g = 0; g < 2; g++) begin
        if (!got_done[g]) begin
          if (cpu_reset_o[g] == 1'b0) begin
            seen_low[g] = 1'b1;
            low_n[g]++;
          end else if (!seen_low[g] && busy_o[g]) begin
            hold_n[g]++;
          end
        end
        if (dv_o[g]) begin
          if ((idx_o[g] != npulse[g][AW-1:0]) || (data_o[g] != rf[idx_o[g]])) bad_d[g]++;
          if (npulse[g] == 0) first_p[g] = cyc;
          last_p[g] = cyc;
          npulse[g]++;
        end
        if (((cpu_reset_o[g] == 1'b0) || !busy_o[g]) && (raddr_o[g] != '0)) bad_a[g]++;
        if (done_o[g] && !got_done[g]) begin
          got_done[g] = 1'b1;
          check({nm, ".", tag(g), ".count"},     64'(cnt_o[g]),       64'(exp_cnt[g]));
          check({nm, ".", tag(g), ".timed_out"}, 64'(to_o[g]),        64'(exp_to[g]));
          check({nm, ".", tag(g), ".pass"},      64'(pass_o[g]),      64'(exp_ps[g]));
          check({nm, ".", tag(g), ".busy_done"}, 64'(busy_o[g]),      64'd0);
          check({nm, ".", tag(g), ".frozen"},    64'(cpu_reset_o[g]), 64'd1);
        end
      end
      // halt for the RUN cycle being observed, counted on the fixed-length instance
      if (cpu_reset_o[1] == 1'b0) ridx++;
      halt  = (h > 0) && (hold ? (ridx >= h) : ((cpu_reset_o[1] == 1'b0) && (ridx == h)));
      start = noise && (busy_o == 2'b11) && ($urandom_range(3) == 0);
      cyc++;
      @(negedge clk);
    end
    halt  = 1'b0;
    start = 1'b0;
    check({nm, ".done_reached"}, 64'({got_done[1], got_done[0]}), 64'd3);
    for (int g = 0; g < 2; g++) begin
      check({nm, ".", tag(g), ".reset_hold"}, 64'(hold_n[g]), 64'(RC));
      check({nm, ".", tag(g), ".run_cycles"}, 64'(low_n[g]),  64'(exp_cnt[g]));
      check({nm, ".", tag(g), ".pulses"},     64'(npulse[g]), 64'(NUM_REGS));
      check({nm, ".", tag(g), ".no_gaps"},    64'(last_p[g] - first_p[g]), 64'(NUM_REGS - 1));
      check({nm, ".", tag(g), ".dump_data"},  64'(bad_d[g]),  64'd0);
      check({nm, ".", tag(g), ".raddr_idle"}, 64'(bad_a[g]),  64'd0);
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check({nm, ".", tag(g), ".done_held"}, 64'(done_o[g]), 64'd1);
      check({nm, ".", tag(g), ".dv_quiet"},  64'(dv_o[g]),   64'd0);
      check({nm, ".", tag(g), ".pass_held"}, 64'(pass_o[g]), 64'(exp_ps[g]));
    end
  endtask

  // Reset raised in the second DUMP cycle must abort both instances at once.
  task automatic abort_test();
    int ridx;
    bit low;
    bit found;
    ridx = 0; low = 1'b0; found = 1'b0;
    @(negedge clk);
    check_en = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; (c < 300) && !found; c++) begin
      if (cpu_reset_o[0] == 1'b0) begin
        low = 1'b1;
        ridx++;
      end else if (low) begin
        found = 1'b1;
      end
      if (!found) begin
        halt = (cpu_reset_o[0] == 1'b0) && (ridx == 5);
        @(negedge clk);
      end
    end
    halt = 1'b0;
    check("abort.reach_dump", 64'(found), 64'd1);
    check("abort.dump0.raddr", 64'(raddr_o[0]), 64'd0);
    check("abort.dump0.dv",    64'(dv_o[0]),    64'd0);
    @(negedge clk);
    check("abort.dump1.raddr", 64'(raddr_o[0]), 64'd1);
    check("abort.dump1.dv",    64'(dv_o[0]),    64'd1);
    check("abort.dump1.idx",   64'(idx_o[0]),   64'd0);
    check("abort.dump1.data",  64'(data_o[0]),  64'(rf[0]));
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{10,  1'b0, 1'b0, 32'h2B, 32'h2A, 10,  1'b0, 1'b1};
    tbl[1] = '{0,   1'b0, 1'b1, 32'h2A, 32'h2A, 100, 1'b1, 1'b0};
    tbl[2] = '{10,  1'b0, 1'b1, 32'h2A, 32'h2A, 10,  1'b0, 1'b1};
    tbl[3] = '{10,  1'b0, 1'b1, 32'h2B, 32'h2A, 10,  1'b0, 1'b0};
    tbl[4] = '{37,  1'b0, 1'b1, 32'h0,  32'h0,  37,  1'b0, 1'b1};
    tbl[5] = '{100, 1'b0, 1'b0, 32'h2B, 32'h2A, 100, 1'b0, 1'b1};
    tbl[6] = '{1,   1'b1, 1'b1, 32'h2A, 32'h2A, 1,   1'b0, 1'b1};
    tbl[7] = '{101, 1'b0, 1'b0, 32'h0,  32'h2A, 100, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b0; halt = 1'b0; check_en = 1'b0; expect_val = '0;
    fill_rf();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle.he1.busy",      64'(busy_o[0]),      64'd0);
    check("idle.he1.cpu_reset", 64'(cpu_reset_o[0]), 64'd1);

    for (int i = 0; i < 8; i++) begin
      fill_rf();
      rf[CHK] = tbl[i].rf2;
      exp_cnt[0] = tbl[i].cnt; exp_to[0] = tbl[i].to; exp_ps[0] = tbl[i].ps;
      model(1'b0, tbl[i].h, tbl[i].chk, tbl[i].ev, exp_cnt[1], exp_to[1], exp_ps[1]);
      do_run($sformatf("vec%0d", i), tbl[i].h, tbl[i].hold, tbl[i].chk, tbl[i].ev, (i % 2) == 1);
    end

    abort_test();
    fill_rf();
    for (int g = 0; g < 2; g++) model(g == 0, 20, 1'b0, '0, exp_cnt[g], exp_to[g], exp_ps[g]);
    do_run("after_abort", 20, 1'b0, 1'b0, '0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      int          h;
      bit          hold, chk;
      logic [31:0] ev;
      fill_rf();
      h    = $urandom_range(110, 0);
      hold = 1'($urandom_range(1, 0));
      chk  = 1'($urandom_range(1, 0));
      ev   = ($urandom_range(1, 0) == 0) ? rf[CHK] : 32'($urandom);
      for (int g = 0; g < 2; g++) model(g == 0, h, chk, ev, exp_cnt[g], exp_to[g], exp_ps[g]);
      do_run($sformatf("rnd%0d", i), h, hold, chk, ev, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
